banked_main_mem: RTL and testbench

- Four-bank, word-interleaved main memory that sits directly downstream of the cache controller. It is the target of the cache controller's mem_addr, mem_data_in, mem_read and mem_write, and it returns mem_data_out, mem_stall and mem_busy.
- Models per-bank occupancy: each bank is busy for a fixed number of cycles after it accepts an access.
- Read data is pipelined, so line fills and evictions can issue one word per cycle to successive banks.

---
 rtl/banked_main_mem_pkg.sv | 25 ++
 rtl/banked_main_mem_bank.sv | 46 ++++
 rtl/banked_main_mem.sv | 108 ++++++++++
 tb/tb_banked_main_mem.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/banked_main_mem_pkg.sv
// Shared constants and address decode for the four-bank interleaved main memory.
package banked_main_mem_pkg;

  localparam int N_BANKS             = 4;
  localparam int BANK_SEL_LSB        = 1;
  localparam int BANK_SEL_W          = 2;
  localparam int DEF_BUSY_CYCLES     = 4;
  localparam int DEF_READ_LAT        = 2;
  localparam int DEF_ADDR_W          = 16;
  localparam int DEF_BANK_DEPTH_LOG2 = 13;

  typedef struct packed {
    logic [BANK_SEL_W-1:0]          bank;
    logic [DEF_BANK_DEPTH_LOG2-1:0] row;
  } addr_split_t;

  // Word-interleaved split: addr[2:1] picks the bank, the bits above pick the row.
  function automatic addr_split_t addr_split(input logic [DEF_ADDR_W-1:0] a);
    addr_split_t s;
    s.bank = a[BANK_SEL_LSB +: BANK_SEL_W];
    s.row  = DEF_BANK_DEPTH_LOG2'(a >> (BANK_SEL_LSB + BANK_SEL_W));
    return s;
  endfunction

endpackage

// File: rtl/banked_main_mem_bank.sv
// One memory bank: word storage, occupancy down-counter and a read capture register.
module banked_main_mem_bank
  import banked_main_mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ROW_W       = DEF_BANK_DEPTH_LOG2,
  parameter int BUSY_CYCLES = DEF_BUSY_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ROW_W-1:0]  row,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rd_data_p0,
  output logic              vld_p0,
  output logic              busy
);

  logic [DATA_W-1:0] mem [2**ROW_W];
  logic [3:0]        busy_cnt;

  // Storage write and read capture; contents survive reset.
  // -- stage p0: array word captured at the accept edge --
  always_ff @(posedge clk) begin
    if (we) mem[row] <= wdata;
    if (re) rd_data_p0 <= mem[row];
  end

  // Occupancy counter reloads on any access and drains to zero; valid tags the capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cnt <= '0;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= re;
      if (we || re)
        busy_cnt <= 4'(BUSY_CYCLES);
      else if (busy_cnt != 4'd0)
        busy_cnt <= busy_cnt - 4'd1;
    end
  end

  assign busy = (busy_cnt != 4'd0);

endmodule

// File: rtl/banked_main_mem.sv
// Four-bank word-interleaved main memory with per-bank occupancy and pipelined reads.
module banked_main_mem
  import banked_main_mem_pkg::*;
#(
  parameter int ADDR_W          = DEF_ADDR_W,
  parameter int DATA_W          = 16,
  parameter int BANK_DEPTH_LOG2 = DEF_BANK_DEPTH_LOG2,
  parameter int BUSY_CYCLES     = DEF_BUSY_CYCLES,
  parameter int READ_LAT        = DEF_READ_LAT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd,
  input  logic              wr,
  output logic [DATA_W-1:0] data_out,
  output logic              rd_valid,
  output logic              stall,
  output logic [3:0]        busy,
  output logic              err
);

  addr_split_t                split;
  logic [BANK_SEL_W-1:0]      bank_sel;
  logic [BANK_DEPTH_LOG2-1:0] row;
  logic                       req;
  logic                       illegal;
  logic                       bank_busy;
  logic                       accept;
  logic [N_BANKS-1:0]         we_vec;
  logic [N_BANKS-1:0]         re_vec;
  logic [DATA_W-1:0]          rd_data_p0 [N_BANKS];
  logic [N_BANKS-1:0]         vld_p0;
  logic [DATA_W-1:0]          ret_data;
  logic                       ret_vld;

  assign split     = addr_split(DEF_ADDR_W'(addr));
  assign bank_sel  = split.bank;
  assign row       = BANK_DEPTH_LOG2'(split.row);

  assign req       = rd ^ wr;
  assign illegal   = (rd & wr) | ((rd | wr) & addr[0]);
  assign bank_busy = busy[bank_sel];
  assign stall     = req & bank_busy & ~illegal;
  assign accept    = req & ~bank_busy & ~addr[0];

  // Steer an accepted request to exactly one bank.
  always_comb begin
    we_vec = '0;
    re_vec = '0;
    if (accept) begin
      we_vec[bank_sel] = wr;
      re_vec[bank_sel] = rd;
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    banked_main_mem_bank #(
      .DATA_W      (DATA_W),
      .ROW_W       (BANK_DEPTH_LOG2),
      .BUSY_CYCLES (BUSY_CYCLES)
    ) u_mem_bank (
      .clk        (clk),
      .rst_n      (rst_n),
      .we         (we_vec[b]),
      .re         (re_vec[b]),
      .row        (row),
      .wdata      (data_in),
      .rd_data_p0 (rd_data_p0[b]),
      .vld_p0     (vld_p0[b]),
      .busy       (busy[b])
    );
  end

  // Return mux: at most one bank holds a valid capture per cycle, its valid bit is the tag.
  always_comb begin
    ret_data = '0;
    ret_vld  = |vld_p0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (vld_p0[b]) ret_data = rd_data_p0[b];
    end
  end

  // Illegal request flagged for exactly the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err <= 1'b0;
    else        err <= illegal;
  end

  if (READ_LAT == DEF_READ_LAT) begin : g_ret_p1
    // -- stage p1: captured word lands on data_out, held until the next return --
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_out <= '0;
        rd_valid <= 1'b0;
      end else begin
        rd_valid <= ret_vld;
        if (ret_vld) data_out <= ret_data;
      end
    end
  end else begin : g_ret_none
    // Only the two-cycle return path exists; other latencies return nothing.
    assign data_out = '0;
    assign rd_valid = 1'b0;
  end

endmodule

// File: tb/tb_banked_main_mem.sv
// Directed self-checking bench for banked_main_mem.
module tb_banked_main_mem;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic        rd;
  logic        wr;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  int checks;
  int failures;

  banked_main_mem dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .addr     (addr),
    .data_in  (data_in),
    .rd       (rd),
    .wr       (wr),
    .data_out (data_out),
    .rd_valid (rd_valid),
    .stall    (stall),
    .busy     (busy),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rd = 1'b0;
    wr = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    addr = a; data_in = d; wr = 1'b1; rd = 1'b0;
    cyc();
    wr = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
    cyc();
    cyc();
    checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL reset_busy got=%b exp=0000", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_write_read();
    addr = 16'h0010; data_in = 16'hBEEF; wr = 1'b1; rd = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL wr_stall got=%b exp=0", stall); end
    cyc();
    wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (busy !== 4'b0001) begin failures++; $display("FAIL wr_busy[%0d] got=%b exp=0001", i, busy); end
      cyc();
    end
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL wr_busy_clear got=%b exp=0000", busy); end
    addr = 16'h0010; rd = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rd_stall got=%b exp=0", stall); end
    cyc();
    rd = 1'b0;
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_t1 got=%b exp=0", rd_valid); end
    checks++; if (busy !== 4'b0001) begin failures++; $display("FAIL rd_busy got=%b exp=0001", busy); end
    cyc();
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL rd_valid_t2 got=%b exp=1", rd_valid); end
    checks++; if (data_out !== 16'hBEEF) begin failures++; $display("FAIL rd_data got=%h exp=beef", data_out); end
    cyc();
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rd_valid_t3 got=%b exp=0", rd_valid); end
    checks++; if (data_out !== 16'hBEEF) begin failures++; $display("FAIL rd_data_hold got=%h exp=beef", data_out); end
    idle(2);
  endtask

  task automatic test_line_fill();
    logic [15:0] fill [4];
    logic [3:0]  ramp [5];
    logic        exp_v;
    fill = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    ramp = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111};
    for (int i = 0; i < 4; i++) do_write(16'h0040 + 16'(2 * i), fill[i]);
    idle(4);
    for (int c = 0; c < 7; c++) begin
      if (c < 4) begin rd = 1'b1; addr = 16'h0040 + 16'(2 * c); end
      else rd = 1'b0;
      #1;
      if (c < 4) begin
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL fill_stall[%0d] got=%b exp=0", c, stall); end
      end
      if (c <= 4) begin
        checks++; if (busy !== ramp[c]) begin failures++; $display("FAIL fill_busy[%0d] got=%b exp=%b", c, busy, ramp[c]); end
      end
      exp_v = (c >= 2) && (c < 6);
      checks++; if (rd_valid !== exp_v) begin failures++; $display("FAIL fill_valid[%0d] got=%b exp=%b", c, rd_valid, exp_v); end
      if (exp_v) begin
        checks++; if (data_out !== fill[c-2]) begin failures++; $display("FAIL fill_data[%0d] got=%h exp=%h", c, data_out, fill[c-2]); end
      end
      cyc();
    end
    idle(2);
  endtask

  task automatic test_conflict();
    logic exp_s;
    logic exp_v;
    do_write(16'h0000, 16'hA000);
    idle(4);
    do_write(16'h0008, 16'h5A5A);
    idle(4);
    for (int c = 0; c < 8; c++) begin
      if (c == 0) begin rd = 1'b1; addr = 16'h0000; end
      else if (c <= 5) begin rd = 1'b1; addr = 16'h0008; end
      else rd = 1'b0;
      #1;
      if (c <= 5) begin
        exp_s = (c >= 1) && (c <= 4);
        checks++; if (stall !== exp_s) begin failures++; $display("FAIL conf_stall[%0d] got=%b exp=%b", c, stall, exp_s); end
      end
      exp_v = (c == 2) || (c == 7);
      checks++; if (rd_valid !== exp_v) begin failures++; $display("FAIL conf_valid[%0d] got=%b exp=%b", c, rd_valid, exp_v); end
      if (c == 2) begin
        checks++; if (data_out !== 16'hA000) begin failures++; $display("FAIL conf_data0 got=%h exp=a000", data_out); end
      end
      if (c == 7) begin
        checks++; if (data_out !== 16'h5A5A) begin failures++; $display("FAIL conf_data1 got=%h exp=5a5a", data_out); end
      end
      cyc();
    end
    idle(2);
  endtask

  task automatic test_illegal();
    do_write(16'h0002, 16'h1234);
    idle(4);
    addr = 16'h0002; data_in = 16'hFFFF; rd = 1'b1; wr = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ill_rw_stall got=%b exp=0", stall); end
    cyc();
    rd = 1'b0; wr = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_rw_err got=%b exp=1", err); end
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL ill_rw_busy got=%b exp=0000", busy); end
    cyc();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_rw_err_end got=%b exp=0", err); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL ill_rw_valid got=%b exp=0", rd_valid); end
    addr = 16'h0003; rd = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL ill_odd_stall got=%b exp=0", stall); end
    cyc();
    rd = 1'b0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ill_odd_err got=%b exp=1", err); end
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL ill_odd_busy got=%b exp=0000", busy); end
    cyc();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL ill_odd_err_end got=%b exp=0", err); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL ill_odd_valid got=%b exp=0", rd_valid); end
    addr = 16'h0002; rd = 1'b1;
    cyc();
    rd = 1'b0;
    cyc();
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL ill_mem_valid got=%b exp=1", rd_valid); end
    checks++; if (data_out !== 16'h1234) begin failures++; $display("FAIL ill_mem_data got=%h exp=1234", data_out); end
    idle(3);
  endtask

  task automatic test_reset_mid();
    do_write(16'h0020, 16'hC0DE);
    idle(4);
    addr = 16'h0020; rd = 1'b1;
    cyc();
    rd = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 4'b0000) begin failures++; $display("FAIL rst_mid_busy got=%b exp=0000", busy); end
    checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL rst_mid_data got=%h exp=0000", data_out); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_valid got=%b exp=0", rd_valid); end
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rst_drop_valid[%0d] got=%b exp=0", i, rd_valid); end
      cyc();
    end
    addr = 16'h0020; rd = 1'b1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_reread_stall got=%b exp=0", stall); end
    cyc();
    rd = 1'b0;
    cyc();
    checks++; if (rd_valid !== 1'b1) begin failures++; $display("FAIL rst_reread_valid got=%b exp=1", rd_valid); end
    checks++; if (data_out !== 16'hC0DE) begin failures++; $display("FAIL rst_reread_data got=%h exp=c0de", data_out); end
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic        exp_v;
    logic [15:0] exp_d;
    for (int c = 0; c < 12; c++) begin
      rd = 1'b0; wr = 1'b0;
      if (c < 4) begin wr = 1'b1; addr = 16'h0100 + 16'(2 * c); data_in = 16'hB000 + 16'(c); end
      else if (c >= 5 && c <= 8) begin rd = 1'b1; addr = 16'h0100 + 16'(2 * (c - 5)); end
      #1;
      if (c != 4 && c <= 8) begin
        checks++; if (stall !== 1'b0) begin failures++; $display("FAIL b2b_stall[%0d] got=%b exp=0", c, stall); end
      end
      exp_v = (c >= 7) && (c <= 10);
      checks++; if (rd_valid !== exp_v) begin failures++; $display("FAIL b2b_valid[%0d] got=%b exp=%b", c, rd_valid, exp_v); end
      if (exp_v) begin
        exp_d = 16'hB000 + 16'(c - 7);
        checks++; if (data_out !== exp_d) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", c, data_out, exp_d); end
      end
      cyc();
    end
    idle(2);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_write_read();
    test_line_fill();
    test_conflict();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
